// File: rtl/seq_det_pkg.sv
// Shared constants, context type and helpers for the time-multiplexed sequence detector.
// Default configuration values live here; the optional match counters use CNT_W.
package seq_det_pkg;

    localparam int DEF_NCH = 4;
    localparam int DEF_PAT_LEN = 3;
    localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 3'b110;

    localparam int CH_W = $clog2(DEF_NCH);
    localparam int FILL_W = $clog2(DEF_PAT_LEN + 1);
    localparam int CNT_W = 8;

    typedef struct packed {
        logic [DEF_PAT_LEN-1:0] hist;
        logic [FILL_W-1:0]      fill;
    } ctx_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/seq_det_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester strictly after the
// last winner; the pointer holds when nobody requests.
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;
    int            idx;

    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                ptr_d    = PW'(idx);
                found    = 1'b1;
            end
        end
    end

    // Pointer starts at the top index so channel 0 is served first after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= PW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/seq_det_sched.sv
// One Moore pattern detector shared round-robin across NCH serial channels.
// Optional per-channel saturating match counters: define SEQ_DET_MATCH_CNT_EN.
module seq_det_sched
    import seq_det_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
    localparam int CW = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] in_valid,
    input  logic [NCH-1:0] in_bit,
    output logic [NCH-1:0] in_ready,
    input  logic [NCH-1:0] ch_clr,
    output logic [NCH-1:0] match_out,
    output logic           det_valid,
    output logic [CW-1:0]  det_ch
`ifdef SEQ_DET_MATCH_CNT_EN
    ,
    input  logic [CW-1:0]    cnt_sel,
    output logic [CNT_W-1:0] cnt_out
`endif
);

    localparam int FW = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(PAT_LEN);

    logic [PAT_LEN-1:0] hist_q [NCH];
    logic [PAT_LEN-1:0] hist_d [NCH];
    logic [FW-1:0]      fill_q [NCH];
    logic [FW-1:0]      fill_d [NCH];
    logic [NCH-1:0]     match_q;
    logic [NCH-1:0]     match_d;
    logic               det_valid_q;
    logic               det_valid_d;
    logic [CW-1:0]      det_ch_q;
    logic [CW-1:0]      det_ch_d;
    logic [NCH-1:0]     eligible;
    logic [PAT_LEN-1:0] next_hist;
    logic [FW-1:0]      next_fill;

    // A clearing channel must not be granted, so its bit stays for a later cycle.
    assign eligible = in_valid & ~ch_clr & {NCH{~reset}};

    rr_arbiter #(
        .N(NCH)
    ) u_arb (
        .clk  (clk),
        .reset(reset),
        .req  (eligible),
        .gnt  (in_ready)
    );

    always_comb begin
        match_d     = match_q;
        det_valid_d = 1'b0;
        det_ch_d    = det_ch_q;
        next_hist   = '0;
        next_fill   = '0;
        for (int i = 0; i < NCH; i++) begin
            hist_d[i] = hist_q[i];
            fill_d[i] = fill_q[i];
        end
        for (int i = 0; i < NCH; i++) begin
            next_hist = {hist_q[i][PAT_LEN-2:0], in_bit[i]};
            next_fill = (fill_q[i] == FILL_FULL) ? fill_q[i] : fill_q[i] + 1'b1;
            if (ch_clr[i]) begin
                hist_d[i]  = '0;
                fill_d[i]  = '0;
                match_d[i] = 1'b0;
            end else if (in_ready[i]) begin
                hist_d[i]  = next_hist;
                fill_d[i]  = next_fill;
                // The fill requirement stops leading-zero patterns matching a cleared history.
                match_d[i] = (next_hist == PATTERN) && (next_fill == FILL_FULL);
                if (match_d[i]) begin
                    det_valid_d = 1'b1;
                    det_ch_d    = CW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                hist_q[i] <= '0;
                fill_q[i] <= '0;
            end
            match_q     <= '0;
            det_valid_q <= 1'b0;
            det_ch_q    <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                hist_q[i] <= hist_d[i];
                fill_q[i] <= fill_d[i];
            end
            match_q     <= match_d;
            det_valid_q <= det_valid_d;
            det_ch_q    <= det_ch_d;
        end
    end

    assign match_out = match_q;
    assign det_valid = det_valid_q;
    assign det_ch    = det_ch_q;

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic [CNT_W-1:0] cnt_out_q;
    logic [CNT_W-1:0] cnt_out_d;

    // Counters follow the registered detection pulse, so they trail det_valid by one edge.
    always_comb begin
        cnt_out_d = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (ch_clr[i]) begin
                cnt_d[i] = '0;
            end else if (det_valid_q && (det_ch_q == CW'(i))) begin
                cnt_d[i] = sat_inc(cnt_q[i]);
            end
            if (cnt_sel == CW'(i)) begin
                cnt_out_d = cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
            cnt_out_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            cnt_out_q <= cnt_out_d;
        end
    end

    assign cnt_out = cnt_out_q;
`endif

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed testbench for seq_det_sched (NCH=4, PAT_LEN=3, PATTERN=110).
// Counter checks run only when SEQ_DET_MATCH_CNT_EN is defined.
module tb_seq_det_sched;

    logic       clk;
    logic       reset;
    logic [3:0] in_valid;
    logic [3:0] in_bit;
    logic [3:0] in_ready;
    logic [3:0] ch_clr;
    logic [3:0] match_out;
    logic       det_valid;
    logic [1:0] det_ch;
`ifdef SEQ_DET_MATCH_CNT_EN
    logic [1:0] cnt_sel;
    logic [7:0] cnt_out;
`endif

    int checks = 0;
    int errors = 0;

    seq_det_sched dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_bit   (in_bit),
        .in_ready (in_ready),
        .ch_clr   (ch_clr),
        .match_out(match_out),
        .det_valid(det_valid),
        .det_ch   (det_ch)
`ifdef SEQ_DET_MATCH_CNT_EN
        ,
        .cnt_sel  (cnt_sel),
        .cnt_out  (cnt_out)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = '0;
        in_bit   = '0;
        ch_clr   = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic send(input int ch, input logic b);
        in_valid     = '0;
        in_bit       = '0;
        in_valid[ch] = 1'b1;
        in_bit[ch]   = b;
        step();
        in_valid = '0;
        in_bit   = '0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 4'b1111;
        in_bit   = 4'b1111;
        ch_clr   = '0;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b want 0000", in_ready);
        end
        step();
        step();
        checks++;
        if (match_out !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_match: got %b want 0000", match_out);
        end
        checks++;
        if (det_valid !== 1'b0 || det_ch !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_det: got %b/%0d want 0/0", det_valid, det_ch);
        end
        in_valid = '0;
        in_bit   = '0;
        reset    = 1'b0;
    endtask

    task automatic test_single();
        logic [4:0] seq;
        seq = 5'b00110;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            in_valid = 4'b0001;
            in_bit   = {3'b000, seq[4-k]};
            #1;
            checks++;
            if (in_ready !== 4'b0001) begin
                errors++;
                $display("[TB] FAIL single_ready bit%0d: got %b want 0001", k, in_ready);
            end
            step();
            checks++;
            if (match_out[0] !== (k == 4) || det_valid !== (k == 4)) begin
                errors++;
                $display("[TB] FAIL single_match bit%0d: got m=%b dv=%b want %b", k, match_out[0], det_valid, (k == 4));
            end
        end
        checks++;
        if (det_ch !== 2'd0) begin
            errors++;
            $display("[TB] FAIL single_det_ch: got %0d want 0", det_ch);
        end
        in_valid = '0;
        in_bit   = '0;
        step();
        checks++;
        if (det_valid !== 1'b0 || match_out[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_hold: got dv=%b m=%b want dv=0 m=1", det_valid, match_out[0]);
        end
    endtask

    task automatic test_overlap();
        logic [5:0] seq;
        logic       exp;
        seq = 6'b110110;
        for (int k = 0; k < 6; k++) begin
            send(1, seq[5-k]);
            exp = (k == 2) || (k == 5);
            checks++;
            if (det_valid !== exp || match_out[1] !== exp) begin
                errors++;
                $display("[TB] FAIL overlap bit%0d: got dv=%b m=%b want %b", k, det_valid, match_out[1], exp);
            end
            if (exp) begin
                checks++;
                if (det_ch !== 2'd1) begin
                    errors++;
                    $display("[TB] FAIL overlap_det_ch bit%0d: got %0d want 1", k, det_ch);
                end
            end
        end
        checks++;
        if (match_out[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overlap_isolation: got ch0 match %b want 1", match_out[0]);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_a [5];
        logic [3:0] exp_b [3];
        exp_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_b = '{4'b0010, 4'b1000, 4'b0001};
        do_reset();
        in_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (in_ready !== exp_a[k]) begin
                errors++;
                $display("[TB] FAIL rr_all slot%0d: got %b want %b", k, in_ready, exp_a[k]);
            end
            step();
        end
        in_valid = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (in_ready !== exp_b[k]) begin
                errors++;
                $display("[TB] FAIL rr_skip slot%0d: got %b want %b", k, in_ready, exp_b[k]);
            end
            step();
        end
        in_valid = '0;
    endtask

    task automatic test_interleave();
        logic [2:0] seq0;
        logic [2:0] seq3;
        logic [3:0] exp_gnt [6];
        logic       exp_det [6];
        int         i0;
        int         i3;
        seq0    = 3'b110;
        seq3    = 3'b000;
        exp_gnt = '{4'b0001, 4'b1000, 4'b0001, 4'b1000, 4'b0001, 4'b1000};
        exp_det = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        i0 = 0;
        i3 = 0;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            in_valid = 4'b1001;
            in_bit   = {seq3[2-(i3 % 3)], 2'b00, seq0[2-(i0 % 3)]};
            #1;
            checks++;
            if (in_ready !== exp_gnt[k]) begin
                errors++;
                $display("[TB] FAIL interleave_gnt slot%0d: got %b want %b", k, in_ready, exp_gnt[k]);
            end
            if (exp_gnt[k][0]) i0++;
            if (exp_gnt[k][3]) i3++;
            step();
            checks++;
            if (det_valid !== exp_det[k] || match_out[3] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL interleave_det slot%0d: got dv=%b m3=%b want dv=%b m3=0", k, det_valid, match_out[3], exp_det[k]);
            end
        end
        in_valid = '0;
        in_bit   = '0;
        checks++;
        if (match_out !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL interleave_final: got %b want 0001", match_out);
        end
    endtask

    task automatic test_clear_and_reset();
        do_reset();
        send(0, 1'b1);
        send(0, 1'b1);
        in_valid = 4'b0001;
        in_bit   = 4'b0000;
        ch_clr   = 4'b0001;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL clr_block: got %b want 0000", in_ready);
        end
        step();
        ch_clr = '0;
        send(0, 1'b0);
        checks++;
        if (match_out[0] !== 1'b0 || det_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clr_no_match: got m=%b dv=%b want 0/0", match_out[0], det_valid);
        end
        send(0, 1'b1);
        send(0, 1'b1);
        send(0, 1'b0);
        checks++;
        if (match_out[0] !== 1'b1 || det_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clr_rematch: got m=%b dv=%b want 1/1", match_out[0], det_valid);
        end
        send(1, 1'b1);
        send(1, 1'b1);
        send(1, 1'b0);
        checks++;
        if (match_out !== 4'b0011) begin
            errors++;
            $display("[TB] FAIL pre_reset_match: got %b want 0011", match_out);
        end
        reset    = 1'b1;
        in_valid = 4'b1111;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL midreset_ready: got %b want 0000", in_ready);
        end
        step();
        checks++;
        if (match_out !== 4'b0000 || det_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_clear: got m=%b dv=%b want 0000/0", match_out, det_valid);
        end
        reset    = 1'b0;
        in_valid = 4'b0110;
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL post_reset_grant: got %b want 0010", in_ready);
        end
        step();
        in_valid = '0;
    endtask

`ifdef SEQ_DET_MATCH_CNT_EN
    task automatic test_match_cnt();
        do_reset();
        cnt_sel = 2'd2;
        send(2, 1'b1);
        send(2, 1'b1);
        send(2, 1'b0);
        step();
        step();
        checks++;
        if (cnt_out !== 8'd1) begin
            errors++;
            $display("[TB] FAIL cnt_first: got %0d want 1", cnt_out);
        end
        for (int t = 0; t < 299; t++) begin
            send(2, 1'b1);
            send(2, 1'b1);
            send(2, 1'b0);
        end
        step();
        step();
        checks++;
        if (cnt_out !== 8'd255) begin
            errors++;
            $display("[TB] FAIL cnt_saturate: got %0d want 255", cnt_out);
        end
        ch_clr = 4'b0100;
        step();
        ch_clr = '0;
        step();
        checks++;
        if (cnt_out !== 8'd0) begin
            errors++;
            $display("[TB] FAIL cnt_clear: got %0d want 0", cnt_out);
        end
    endtask
`endif

    initial begin
        reset    = 1'b1;
        in_valid = '0;
        in_bit   = '0;
        ch_clr   = '0;
`ifdef SEQ_DET_MATCH_CNT_EN
        cnt_sel = '0;
`endif
        test_reset();
        test_single();
        test_overlap();
        test_round_robin();
        test_interleave();
        test_clear_and_reset();
`ifdef SEQ_DET_MATCH_CNT_EN
        test_match_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_det_sched.md
Name: seq_det_sched

Overview:
- Time-multiplexes one Moore-style serial pattern detector across NCH independent serial bit channels.
- Keeps a per-channel detection context: shift history plus a fill count.
- Grants one channel per cycle round-robin, updates that channel's context, and emits a registered match indication.
- Sits between the per-channel serial sources and downstream event logic, replacing NCH separate detector instances.

Parameters:
- NCH, 4, number of serial channels (2..16).
- PAT_LEN, 3, pattern length in bits (2..8).
- PATTERN, 3'b110, target sequence, MSB = oldest bit.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- reset, input, 1, synchronous, active-high.
- in_valid, input, NCH, per-channel bit available.
- in_bit, input, NCH, per-channel serial data bit.
- in_ready, output, NCH, one-hot grant; a bit is consumed when in_valid[i] & in_ready[i].
- ch_clr, input, NCH, per-channel context clear.
- match_out, output, NCH, per-channel Moore output; high while that channel's last PAT_LEN accepted bits equal PATTERN.
- det_valid, output, 1, one-cycle pulse: the channel processed last cycle reached a match.
- det_ch, output, $clog2(NCH), channel index qualifying det_valid.

Behaviour:
- Reset (synchronous, active-high):
  - All contexts cleared: history 0, fill count 0.
  - match_out = 0, det_valid = 0, det_ch = 0.
  - RR pointer = NCH-1, so channel 0 has first priority.
  - in_ready = 0 while reset is high; any valid bits are not consumed.
- Eligibility: channel i is eligible when in_valid[i] & ~ch_clr[i] & ~reset.
- Arbitration:
  - in_ready is combinational.
  - Grant the first eligible channel strictly after the RR pointer, wrapping from NCH-1 to 0.
  - At most one bit is ever granted.
  - On a grant, the pointer updates to the granted index.
  - With no eligible channel, in_ready = 0 and the pointer holds.
- Context update on grant of channel g (at the clock edge):
  - hist[g] <= {hist[g][PAT_LEN-2:0], in_bit[g]}.
  - fill[g] <= min(fill[g]+1, PAT_LEN).
  - match_out[g] <= (next hist == PATTERN) && (next fill == PAT_LEN).
  - Overlapping matches count, e.g. 110110 gives two matches.
- match_out[i] is registered and holds its value until channel i's next accepted bit, a clear, or reset.
- det_valid <= 1 and det_ch <= g only when the granted update sets match_out[g] = 1; otherwise det_valid <= 0. Latency: 1 cycle from handshake.
- ch_clr[i]: at the edge, hist[i] = 0, fill[i] = 0, match_out[i] = 0. Channel i is ineligible in that cycle.
- Reset wins over every other event; ch_clr wins over a grant. Non-granted channels' contexts never change.
- The fill count blocks false matches when PATTERN contains leading zeros, e.g. pattern 001 on a freshly cleared history.

Optional Feature:
- Macro: SEQ_DET_MATCH_CNT_EN.
- With the macro defined:
  - Adds per-channel 8-bit saturating match counters, incremented whenever det_valid fires for that channel and holding at 255.
  - Adds ports cnt_sel (input, $clog2(NCH)) and cnt_out (output, 8, registered: the value of counter cnt_sel, 1-cycle read latency).
  - Counters clear on reset or on ch_clr[i].
- Without the macro: no counters, no extra ports; all other behaviour identical.

Decomposition:
- Shared package seq_det_pkg holds:
  - localparam CH_W = $clog2(NCH) and FILL_W = $clog2(PAT_LEN+1).
  - A typedef for the channel context struct {hist, fill}.
  - The counter width constant (8).
- One natural sub-module: rr_arbiter (NCH-wide request in, one-hot grant out, registered pointer with hold-on-idle), reusable elsewhere.

Test Plan:
- Single channel, pattern 110: ch0 bits 0,0,1,1,0, one per cycle.
  - match_out[0] rises on the edge after the 5th bit.
  - det_valid = 1 with det_ch = 0 for exactly one cycle.
- Overlap: ch1 bits 1,1,0,1,1,0.
  - det_valid fires after the 3rd and 6th bits.
  - match_out[1] drops after the 4th bit.
- Round-robin: all four in_valid held high from reset release.
  - in_ready sequence is 0001, 0010, 0100, 1000, 0001.
  - Dropping ch2's valid gives 0001, 0010, 1000, 0001.
- Interleaving isolation: ch0 fed 1,1,0 while ch3 is fed 0,0,0 in alternating grants.
  - Only ch0 matches; match_out[3] stays 0.
- ch_clr and reset mid-operation:
  - Assert ch_clr[0] after ch0 receives 1,1. ch_clr[0] blocks the ch0 grant that cycle; then a following 0 does not match.
  - Reset asserted mid-stream clears all match_out and forces in_ready = 0.
  - After release, the first grant goes to the lowest eligible channel.
- SEQ_DET_MATCH_CNT_EN: 300 consecutive 110 triplets on ch2.
  - With cnt_sel = 2, cnt_out saturates at 255.
  - ch_clr[2] returns it to 0 one cycle later.
